// File: rtl/core_reg_file_mp.sv
// Multi-port register file with write-to-read bypass and a pending-write scoreboard.
// Reads and scoreboard lookups see this cycle's writes, clears and allocation.
module core_reg_file_mp #(
   parameter int WIDTH    = 32,
   parameter int NUM_REGS = 16,
   parameter int NUM_RD   = 2,
   parameter int NUM_WR   = 2,
   parameter int ZERO_R0  = 0,
   localparam int RW      = $clog2(NUM_REGS)
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic [NUM_RD*RW-1:0]     i_rd_r,
   input  logic [NUM_RD-1:0]        i_rd_stall,
   output logic [NUM_RD*WIDTH-1:0]  o_rd_value,
   output logic [NUM_RD-1:0]        o_rd_busy,
   input  logic [NUM_WR-1:0]        i_wr_enable,
   input  logic [NUM_WR*RW-1:0]     i_wr_r,
   input  logic [NUM_WR*WIDTH-1:0]  i_wr_value,
   input  logic                     i_alloc_en,
   input  logic [RW-1:0]            i_alloc_r,
   output logic [NUM_REGS-1:0]      o_busy
);

   localparam logic [RW:0] NUM_REGS_W = (RW+1)'(NUM_REGS);

   logic [WIDTH-1:0]        r_file [NUM_REGS];
   logic [NUM_REGS-1:0]     r_busy;
   logic [NUM_RD*WIDTH-1:0] r_rd_value;
   logic [NUM_RD-1:0]       r_rd_busy;

   logic [WIDTH-1:0]        w_file_next [NUM_REGS];
   logic [NUM_REGS-1:0]     w_busy_next;
   logic [NUM_WR-1:0]       w_wr_ok;
   logic                    w_alloc_ok;
   logic [NUM_RD*WIDTH-1:0] w_rd_value_next;
   logic [NUM_RD-1:0]       w_rd_busy_next;

   // An address is usable if it is in range and not the hardwired-zero r0.
   function automatic logic addr_ok(input logic [RW-1:0] a);
      addr_ok = ({1'b0, a} < NUM_REGS_W) && !((ZERO_R0 != 0) && (a == '0));
   endfunction

   always_comb begin
      for (int j = 0; j < NUM_WR; j++) begin
         w_wr_ok[j] = i_wr_enable[j] && addr_ok(i_wr_r[j*RW +: RW]);
      end
      w_alloc_ok = i_alloc_en && addr_ok(i_alloc_r);
   end

   // Ascending port order lets the highest enabled port win a same-register conflict.
   always_comb begin
      for (int k = 0; k < NUM_REGS; k++) begin
         w_file_next[k] = r_file[k];
         for (int j = 0; j < NUM_WR; j++) begin
            if (w_wr_ok[j] && (i_wr_r[j*RW +: RW] == RW'(k))) begin
               w_file_next[k] = i_wr_value[j*WIDTH +: WIDTH];
            end
         end
      end
   end

   // Clears first, then the set, so a new producer supersedes a retiring one.
   always_comb begin
      w_busy_next = r_busy;
      for (int j = 0; j < NUM_WR; j++) begin
         if (w_wr_ok[j]) begin
            w_busy_next[i_wr_r[j*RW +: RW]] = 1'b0;
         end
      end
      if (w_alloc_ok) begin
         w_busy_next[i_alloc_r] = 1'b1;
      end
   end

   always_comb begin
      logic [RW-1:0] v_addr;
      v_addr          = '0;
      w_rd_value_next = '0;
      w_rd_busy_next  = '0;
      for (int i = 0; i < NUM_RD; i++) begin
         v_addr = i_rd_r[i*RW +: RW];
         if (addr_ok(v_addr)) begin
            w_rd_value_next[i*WIDTH +: WIDTH] = w_file_next[v_addr];
            w_rd_busy_next[i]                 = w_busy_next[v_addr];
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         for (int k = 0; k < NUM_REGS; k++) begin
            r_file[k] <= '0;
         end
         r_busy     <= '0;
         r_rd_value <= '0;
         r_rd_busy  <= '0;
      end else begin
         for (int k = 0; k < NUM_REGS; k++) begin
            r_file[k] <= w_file_next[k];
         end
         r_busy <= w_busy_next;
         for (int i = 0; i < NUM_RD; i++) begin
            if (!i_rd_stall[i]) begin
               r_rd_value[i*WIDTH +: WIDTH] <= w_rd_value_next[i*WIDTH +: WIDTH];
               r_rd_busy[i]                 <= w_rd_busy_next[i];
            end
         end
      end
   end

   assign o_rd_value = r_rd_value;
   assign o_rd_busy  = r_rd_busy;
   assign o_busy     = r_busy;

endmodule

// File: tb/tb_core_reg_file_mp.sv
// Directed bench for core_reg_file_mp: one ordinary-r0 instance and one hardwired-zero-r0
// instance share stimulus; expected values are hand-derived constants.
module tb_core_reg_file_mp;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  rd_r = '0;
   logic [1:0]  rd_stall = '0;
   logic [1:0]  wr_enable = '0;
   logic [7:0]  wr_r = '0;
   logic [63:0] wr_value = '0;
   logic        alloc_en = 1'b0;
   logic [3:0]  alloc_r = '0;

   logic [63:0] rd_value, z_rd_value;
   logic [1:0]  rd_busy, z_rd_busy;
   logic [15:0] busy, z_busy;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   core_reg_file_mp #(.ZERO_R0(0)) dut (
      .i_clk(clk), .i_rst(rst), .i_rd_r(rd_r), .i_rd_stall(rd_stall),
      .o_rd_value(rd_value), .o_rd_busy(rd_busy), .i_wr_enable(wr_enable),
      .i_wr_r(wr_r), .i_wr_value(wr_value), .i_alloc_en(alloc_en),
      .i_alloc_r(alloc_r), .o_busy(busy)
   );

   core_reg_file_mp #(.ZERO_R0(1)) dut_z (
      .i_clk(clk), .i_rst(rst), .i_rd_r(rd_r), .i_rd_stall(rd_stall),
      .o_rd_value(z_rd_value), .o_rd_busy(z_rd_busy), .i_wr_enable(wr_enable),
      .i_wr_r(wr_r), .i_wr_value(wr_value), .i_alloc_en(alloc_en),
      .i_alloc_r(alloc_r), .o_busy(z_busy)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      wr_enable = '0;
      alloc_en  = 1'b0;
      rd_stall  = '0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      checks++;
      if (busy !== 16'h0 || z_busy !== 16'h0) begin
         errors++;
         $display("FAIL reset_busy: got %h/%h expected 0", busy, z_busy);
      end
      for (int a = 0; a < 16; a++) begin
         rd_r = {4'(a), 4'(a)};
         tick();
         checks++;
         if (rd_value !== 64'h0 || rd_busy !== 2'b00) begin
            errors++;
            $display("FAIL reset_read r%0d: got value %h busy %b expected 0", a, rd_value, rd_busy);
         end
      end
   endtask

   task automatic test_bypass();
      idle();
      wr_enable      = 2'b01;
      wr_r[3:0]      = 4'd3;
      wr_value[31:0] = 32'hDEADBEEF;
      rd_r           = {4'd3, 4'd0};
      tick();
      checks++;
      if (rd_value[63:32] !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL bypass_port1: got %h expected deadbeef", rd_value[63:32]);
      end
      wr_enable = 2'b00;
      rd_r      = {4'd0, 4'd3};
      tick();
      checks++;
      if (rd_value[31:0] !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL stored_port0: got %h expected deadbeef", rd_value[31:0]);
      end
   endtask

   task automatic test_write_conflict();
      idle();
      wr_enable = 2'b11;
      wr_r      = {4'd5, 4'd5};
      wr_value  = {32'h22, 32'h11};
      rd_r      = {4'd0, 4'd5};
      tick();
      checks++;
      if (rd_value[31:0] !== 32'h22) begin
         errors++;
         $display("FAIL conflict_bypass: got %h expected 22", rd_value[31:0]);
      end
      wr_enable = 2'b00;
      rd_r      = {4'd5, 4'd0};
      tick();
      checks++;
      if (rd_value[63:32] !== 32'h22) begin
         errors++;
         $display("FAIL conflict_stored: got %h expected 22", rd_value[63:32]);
      end
      wr_enable = 2'b11;
      wr_r      = {4'd9, 4'd8};
      wr_value  = {32'h99, 32'h88};
      rd_r      = {4'd0, 4'd0};
      tick();
      wr_enable = 2'b00;
      rd_r      = {4'd9, 4'd8};
      tick();
      checks++;
      if (rd_value !== {32'h99, 32'h88}) begin
         errors++;
         $display("FAIL dual_write: got %h expected 0000009900000088", rd_value);
      end
   endtask

   task automatic test_scoreboard();
      idle();
      alloc_en = 1'b1;
      alloc_r  = 4'd7;
      rd_r     = {4'd0, 4'd7};
      tick();
      checks++;
      if (busy[7] !== 1'b1 || rd_busy[0] !== 1'b1) begin
         errors++;
         $display("FAIL alloc_set: got busy7 %b rd_busy %b expected 1", busy[7], rd_busy[0]);
      end
      alloc_en = 1'b0;
      tick();
      tick();
      checks++;
      if (busy[7] !== 1'b1) begin
         errors++;
         $display("FAIL alloc_hold: got %b expected 1", busy[7]);
      end
      wr_enable       = 2'b10;
      wr_r[7:4]       = 4'd7;
      wr_value[63:32] = 32'h77;
      tick();
      checks++;
      if (busy[7] !== 1'b0 || rd_busy[0] !== 1'b0 || rd_value[31:0] !== 32'h77) begin
         errors++;
         $display("FAIL write_clear: got busy7 %b rd_busy %b value %h expected 0 0 77",
                  busy[7], rd_busy[0], rd_value[31:0]);
      end
      wr_enable = 2'b10;
      alloc_en  = 1'b1;
      tick();
      checks++;
      if (busy[7] !== 1'b1 || rd_busy[0] !== 1'b1) begin
         errors++;
         $display("FAIL set_wins: got busy7 %b rd_busy %b expected 1", busy[7], rd_busy[0]);
      end
      alloc_en = 1'b0;
      tick();
      checks++;
      if (busy !== 16'h0) begin
         errors++;
         $display("FAIL final_clear: got %h expected 0", busy);
      end
      wr_enable = 2'b00;
   endtask

   task automatic test_stall();
      idle();
      wr_enable      = 2'b01;
      wr_r[3:0]      = 4'd2;
      wr_value[31:0] = 32'h5;
      rd_r           = {4'd2, 4'd2};
      tick();
      checks++;
      if (rd_value[31:0] !== 32'h5) begin
         errors++;
         $display("FAIL stall_pre: got %h expected 5", rd_value[31:0]);
      end
      rd_stall = 2'b01;
      for (int c = 0; c < 3; c++) begin
         wr_enable      = (c < 2) ? 2'b01 : 2'b00;
         wr_value[31:0] = (c == 0) ? 32'hA : 32'hB;
         tick();
         checks++;
         if (rd_value[31:0] !== 32'h5) begin
            errors++;
            $display("FAIL stall_hold c%0d: got %h expected 5", c, rd_value[31:0]);
         end
         checks++;
         if (rd_value[63:32] !== ((c == 0) ? 32'hA : 32'hB)) begin
            errors++;
            $display("FAIL stall_other_port c%0d: got %h", c, rd_value[63:32]);
         end
      end
      rd_stall = 2'b00;
      tick();
      checks++;
      if (rd_value[31:0] !== 32'hB) begin
         errors++;
         $display("FAIL stall_release: got %h expected b", rd_value[31:0]);
      end
   endtask

   task automatic test_zero_r0();
      idle();
      wr_enable      = 2'b01;
      wr_r[3:0]      = 4'd0;
      wr_value[31:0] = 32'hFF;
      alloc_en       = 1'b1;
      alloc_r        = 4'd0;
      rd_r           = {4'd0, 4'd0};
      tick();
      checks++;
      if (z_rd_value !== 64'h0 || z_rd_busy !== 2'b00 || z_busy[0] !== 1'b0) begin
         errors++;
         $display("FAIL zero_r0: got value %h rd_busy %b busy0 %b expected 0",
                  z_rd_value, z_rd_busy, z_busy[0]);
      end
      checks++;
      if (rd_value[31:0] !== 32'hFF || rd_busy[0] !== 1'b1 || busy[0] !== 1'b1) begin
         errors++;
         $display("FAIL plain_r0: got value %h rd_busy %b busy0 %b expected ff 1 1",
                  rd_value[31:0], rd_busy[0], busy[0]);
      end
      idle();
      tick();
      checks++;
      if (z_rd_value !== 64'h0 || z_busy !== 16'h0) begin
         errors++;
         $display("FAIL zero_r0_stored: got %h busy %h expected 0", z_rd_value, z_busy);
      end
   endtask

   task automatic test_reset_mid();
      idle();
      rst            = 1'b1;
      rd_stall       = 2'b11;
      wr_enable      = 2'b01;
      wr_r[3:0]      = 4'd6;
      wr_value[31:0] = 32'h66;
      alloc_en       = 1'b1;
      alloc_r        = 4'd4;
      rd_r           = {4'd6, 4'd6};
      tick();
      checks++;
      if (rd_value !== 64'h0 || rd_busy !== 2'b00 || busy !== 16'h0) begin
         errors++;
         $display("FAIL reset_mid: got value %h rd_busy %b busy %h expected 0",
                  rd_value, rd_busy, busy);
      end
      rst = 1'b0;
      idle();
      rd_r = {4'd2, 4'd6};
      tick();
      checks++;
      if (rd_value !== 64'h0 || busy !== 16'h0) begin
         errors++;
         $display("FAIL reset_discard: got %h busy %h expected 0", rd_value, busy);
      end
   endtask

   initial begin
      test_reset();
      test_bypass();
      test_write_conflict();
      test_scoreboard();
      test_stall();
      test_zero_r0();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
